seq_chunk_adder: RTL and testbench
==================================

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, and CHUNK >= 1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  operand set a/b/cin present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in.
REQ-010 out_valid  output  1  result present on sum/cout.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  WIDTH  registered result.
REQ-013 cout  output  1  registered carry-out of the MSB chunk.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; NCHUNK = WIDTH/CHUNK.
REQ-015 IDLE: in_ready=1, out_valid=0; an accept occurs when in_valid & in_ready are high on a clock edge; that edge latches a, b and cin and enters RUN with chunk index 0.
REQ-016 RUN: each cycle adds chunk k of A and B (bits k*CHUNK+CHUNK-1 : k*CHUNK) plus the carry register, writes the chunk of sum and updates the carry; k increments, and after chunk NCHUNK-1 the FSM enters DONE.
REQ-017 Latency: out_valid SHALL rise exactly NCHUNK cycles after the accept edge.
REQ-018 DONE: out_valid=1; sum/cout stable until out_valid & out_ready on an edge, which returns the FSM to IDLE.
REQ-019 in_ready SHALL be 0 in RUN and DONE; in_valid and operand changes in those states SHALL be ignored and SHALL NOT corrupt the result.
REQ-020 Result SHALL equal the {cout,sum} = a + b + cin modulo 2^(WIDTH+1); wrap-around at all-ones operands SHALL produce cout=1.
REQ-021 CHUNK == WIDTH SHALL be legal: one RUN cycle, latency 1.
REQ-022 Throughput: one operation per NCHUNK+2 cycles when out_ready is held high.

Reset
REQ-023 rst SHALL force IDLE, in_ready=1, out_valid=0, sum=0, cout=0, carry register=0 and chunk index=0 on the next edge.
REQ-024 rst asserted in RUN or DONE SHALL abort the operation, discard the partial result, and not assert out_valid.
REQ-025 rst SHALL take priority over every simultaneous handshake event.

Configuration
REQ-026 Macro SEQ_CHUNK_ADDER_SUB_EN: when defined, the block SHALL add a 1-bit input port sub, sampled at accept.
REQ-027 When sub=1, the block SHALL compute a - b - cin as a + ~b + ~cin, and cout SHALL be the not-borrow; when sub=0, the block SHALL add as in REQ-020.
REQ-028 When the macro is undefined, the block SHALL have no sub port and no subtract logic, and SHALL add only.

Structure
REQ-029 Package seq_adder_pkg SHALL hold the FSM state encoding (IDLE, RUN, DONE) and the default WIDTH/CHUNK constants.
REQ-030 The design SHALL contain one sub-module, chunk_adder: a combinational CHUNK-bit ripple adder (inputs x, y, ci; outputs s, co), instantiated once in the datapath.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-031 Wrap-around: accept a=FFFF, b=0001, cin=0 -> sum=0000, cout=1, out_valid high 4 cycles after accept.
REQ-032 Backpressure: a=1234, b=4321, cin=1 with out_ready=0 for 5 cycles -> sum=5556, cout=0 held stable, in_ready=0 throughout, then return to IDLE one edge after out_ready=1.
REQ-033 Ignored input: in_valid=1 with new operands during RUN -> first result unaffected; new operands accepted only after return to IDLE.
REQ-034 Reset mid-RUN: rst pulsed 2 cycles after accepting a=8000, b=8000 -> out_valid never rises, sum=0000, cout=0, in_ready=1.
REQ-035 Subtract (SEQ_CHUNK_ADDER_SUB_EN defined): sub=1, a=0005, b=0007, cin=0 -> sum=FFFE, cout=0; sub=1, a=0007, b=0005 -> sum=0002, cout=1.
REQ-036 Single-chunk (CHUNK=16): a=00FF, b=0001 -> sum=0100, cout=0, out_valid 1 cycle after accept.

Source files
------------

// File: rtl/seq_adder_pkg.sv
// Package for the sequential chunk adder.
// Holds the FSM state encoding and the default operand/chunk widths.
package seq_adder_pkg;

    // Default operand width and bits added per cycle.
    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,  // waiting for an operand set
        RUN  = 2'd1,  // adding one chunk per cycle
        DONE = 2'd2   // result held until the consumer takes it
    } state_t;

endpackage : seq_adder_pkg

// File: rtl/seq_chunk_adder_chunk.sv
// chunk_adder: combinational W-bit ripple-carry adder.
// Ports:
//   x, y : W-bit addends
//   ci   : carry in
//   s    : W-bit sum
//   co   : carry out of the top bit
module chunk_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic c;

    always_comb begin
        s = '0;
        c = ci;
        for (int i = 0; i < W; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        co = c;
    end

endmodule : chunk_adder

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder that processes CHUNK bits per clock.
// An operand set is taken in IDLE, added chunk by chunk (LSB first) in RUN,
// and the registered result is offered in DONE until the consumer accepts.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds its data stable while valid is high and
// ready is low. in_ready is high only in IDLE, out_valid only in DONE.
//
// Optional feature: define SEQ_CHUNK_ADDER_SUB_EN to add the `sub` input.
// With sub=1 at accept the block computes a - b - cin (as a + ~b + ~cin) and
// cout is the not-borrow flag.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake
//   a, b, cin           : operands and carry in
//   sub                 : subtract select (only with SEQ_CHUNK_ADDER_SUB_EN)
//   out_valid, out_ready: result handshake
//   sum, cout           : registered result and carry out
//   state               : current FSM state, for observation
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output state_t           state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic              carry_q, cout_q;
    logic [IDXW-1:0]   idx_q;

    logic              accept, release_res, last_chunk;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    int                offset;
    logic [CHUNK-1:0]  x_chunk, y_chunk, s_chunk;
    logic              co_chunk;
    logic [WIDTH-1:0]  chunk_mask;

    assign accept      = in_valid & in_ready;
    assign release_res = out_valid & out_ready;
    assign last_chunk  = (idx_q == IDXW'(NCHUNK - 1));

    // Subtraction is folded into the operands at accept time so the RUN
    // datapath is the same adder in both modes.
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    assign b_eff   = sub ? ~b   : b;
    assign cin_eff = sub ? ~cin : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)      state_d = RUN;
            RUN:     if (last_chunk)  state_d = DONE;
            DONE:    if (release_res) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign state = state_q;
    assign sum   = sum_q;
    assign cout  = cout_q;

    // ---------------- Datapath ----------------
    // Bit offset of the chunk being added this cycle.
    assign offset     = int'(idx_q) * CHUNK;
    assign x_chunk    = CHUNK'(a_q >> offset);
    assign y_chunk    = CHUNK'(b_q >> offset);
    assign chunk_mask = WIDTH'({CHUNK{1'b1}}) << offset;

    chunk_adder #(.W(CHUNK)) u_chunk_adder (
        .x  (x_chunk),
        .y  (y_chunk),
        .ci (carry_q),
        .s  (s_chunk),
        .co (co_chunk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= b_eff;
                        carry_q <= cin_eff;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    // Replace only the current chunk of the sum register.
                    sum_q   <= (sum_q & ~chunk_mask) | ((WIDTH'(s_chunk) << offset) & chunk_mask);
                    carry_q <= co_chunk;
                    if (last_chunk) begin
                        cout_q <= co_chunk;
                        idx_q  <= '0;
                    end else begin
                        idx_q  <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : seq_chunk_adder

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder (WIDTH=16, CHUNK=4) plus a
// single-chunk instance (CHUNK=16). Expected results come from plain integer
// arithmetic on the operands.
module tb_seq_chunk_adder;
    import seq_adder_pkg::*;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int NC = W / CH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT 0 (CHUNK=4) ----------------
    logic         in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [W-1:0] a, b, sum;
    state_t       state;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    logic         sub;
`endif

    seq_chunk_adder #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .state     (state)
    );

    // ---------------- DUT 1 (CHUNK=WIDTH) ----------------
    logic         in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1;
    logic [W-1:0] a1, b1, sum1;
    state_t       state1;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(W)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .sub       (1'b0),
`endif
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .state     (state1)
    );

    // ---------------- scoreboard ----------------
    int           checks = 0;
    int           errors = 0;
    logic [W:0]   exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {cout,sum}: add gives the 17-bit sum; subtract gives a-b-cin with
    // cout set when no borrow occurred.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        int t;
        logic [31:0] tv;
        if (s) begin
            t  = int'(x) - int'(y) - int'(c);
            tv = t;
            return {t >= 0, tv[W-1:0]};
        end
        t  = int'(x) + int'(y) + int'(c);
        tv = t;
        return tv[W:0];
    endfunction

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic cv, input logic sv);
        a = av; b = bv; cin = cv;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        sub = sv;
`endif
        in_valid  = 1'b1;
        out_ready = 1'b0;
        exp_q.push_back(model(av, bv, cv, sv));
        check("in_ready_at_accept", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op(input string tag, input int lat, input int hold);
        logic [W:0] e;
        e = exp_q.pop_front();
        check({tag, "_latency"}, 32'(lat), 32'(NC));
        check({tag, "_sum"},  32'(sum),  32'(e[W-1:0]));
        check({tag, "_cout"}, 32'(cout), 32'(e[W]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(in_ready),  32'd0);
            check({tag, "_hold_sum"},   32'(sum),  32'(e[W-1:0]));
            check({tag, "_hold_cout"},  32'(cout), 32'(e[W]));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_release_ready"}, 32'(in_ready),  32'd1);
        out_ready = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int lat, n;
        logic [W-1:0] ra, rb;
        logic rc, rs;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        sub = 1'b0;
`endif
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum",       32'(sum),       32'd0);
        check("reset_cout",      32'(cout),      32'd0);
        check("reset_state",     32'(state),     32'(IDLE));

        // Wrap-around at all-ones.
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("wrap_run_ready", 32'(in_ready), 32'd0);
        wait_done(lat);
        finish_op("wrap", lat, 0);

        // Backpressure: result held for 5 cycles.
        start_op(16'h1234, 16'h4321, 1'b1, 1'b0);
        wait_done(lat);
        finish_op("backpressure", lat, 5);

        // New operands offered during RUN are ignored until IDLE.
        start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
        check("ignore_run_ready", 32'(in_ready), 32'd0);
        wait_done(lat);
        finish_op("ignore_first", lat, 1);
        // finish_op's release edge returned to IDLE; held in_valid is taken now.
        exp_q.push_back(model(16'hAAAA, 16'h5555, 1'b1, 1'b0));
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat);
        finish_op("ignore_second", lat, 0);

        // Reset two cycles into RUN aborts the operation.
        start_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NC + 3; i++) begin
            check("abort_no_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        check("abort_sum",   32'(sum),      32'd0);
        check("abort_cout",  32'(cout),     32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);

        // Throughput with in_valid and out_ready held high.
        a = 16'h0003; b = 16'h0004; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n = 1;
        while (in_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("throughput_spacing", 32'(n), 32'(NC + 2));
        exp_q.push_back(model(16'h0003, 16'h0004, 1'b0, 1'b0));
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        wait_done(lat);
        finish_op("throughput", lat, 0);

`ifdef SEQ_CHUNK_ADDER_SUB_EN
        start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_done(lat);
        finish_op("sub_borrow", lat, 0);
        start_op(16'h0007, 16'h0005, 1'b0, 1'b1);
        wait_done(lat);
        finish_op("sub_noborrow", lat, 0);
`endif

        // Random operations with random backpressure.
        for (int k = 0; k < 16; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
`ifdef SEQ_CHUNK_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            start_op(ra, rb, rc, rs);
            wait_done(lat);
            finish_op("random", lat, $urandom_range(0, 2));
        end

        // Single-chunk instance: latency of one cycle.
        a1 = 16'h00FF; b1 = 16'h0001; cin1 = 1'b0; in_valid1 = 1'b1;
        check("single_ready", 32'(in_ready1), 32'd1);
        @(negedge clk);
        in_valid1 = 1'b0;
        lat = 0;
        while (out_valid1 !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("single_latency", 32'(lat),   32'd1);
        check("single_sum",     32'(sum1),  32'h0100);
        check("single_cout",    32'(cout1), 32'd0);
        out_ready1 = 1'b1;
        @(negedge clk);
        check("single_release", 32'(out_valid1), 32'd0);
        out_ready1 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_chunk_adder
